// File: rtl/debounce_pkg.sv
// Shared constants and counter-width helpers for the debounce_edge block.
package debounce_pkg;

    localparam int DEBNC_CLOCKS_DEF = 16;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int HOLD_CLOCKS_DEF  = 1024;

    // Debounce counter must be able to represent 0..DEBNC_CLOCKS.
    function automatic int debnc_cnt_width(input int debnc_clocks);
        return $clog2(debnc_clocks + 1);
    endfunction

    // Hold counter saturates at HOLD_CLOCKS, so it needs 0..HOLD_CLOCKS.
    function automatic int hold_cnt_width(input int hold_clocks);
        return $clog2(hold_clocks + 1);
    endfunction

endpackage

// File: rtl/debounce_edge_channel.sv
// One debounced channel: synchroniser, mismatch counter, level register,
// registered rise/fall pulses and a one-shot long-press detector.
module debounce_edge_channel
    import debounce_pkg::*;
#(
    parameter int   DEBNC_CLOCKS = DEBNC_CLOCKS_DEF,
    parameter int   SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int   HOLD_CLOCKS  = HOLD_CLOCKS_DEF,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    output logic signal_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic hold_pulse,
    output logic event_next
);

    localparam int DW = debnc_cnt_width(DEBNC_CLOCKS);
    localparam int HW = hold_cnt_width(HOLD_CLOCKS);
    localparam logic [DW-1:0] DEBNC_LAST = DW'(DEBNC_CLOCKS - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CLOCKS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CLOCKS - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_bit;
    logic [DW-1:0]          debnc_cnt_reg, debnc_cnt_next;
    logic [HW-1:0]          hold_cnt_reg, hold_cnt_next;
    logic                   level_reg, level_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;
    logic                   hold_reg, hold_next;

    assign sync_bit = sync_reg[SYNC_STAGES-1];

    always_comb begin
        debnc_cnt_next = '0;
        level_next     = level_reg;
        rise_next      = 1'b0;
        fall_next      = 1'b0;
        if (sync_bit != level_reg) begin
            if (debnc_cnt_reg == DEBNC_LAST) begin
                level_next = ~level_reg;
                rise_next  = ~level_reg;
                fall_next  = level_reg;
            end else begin
                debnc_cnt_next = debnc_cnt_reg + 1'b1;
            end
        end
    end

    // Hold count follows the next level so the first high cycle counts as 1
    // and HOLD_CLOCKS=1 fires together with the rise pulse.
    always_comb begin
        hold_cnt_next = '0;
        hold_next     = 1'b0;
        if (level_next) begin
            if (hold_cnt_reg != HOLD_MAX) begin
                hold_cnt_next = hold_cnt_reg + 1'b1;
            end else begin
                hold_cnt_next = hold_cnt_reg;
            end
            hold_next = (hold_cnt_reg == HOLD_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg      <= {SYNC_STAGES{RESET_LEVEL}};
            debnc_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
            level_reg     <= RESET_LEVEL;
            rise_reg      <= 1'b0;
            fall_reg      <= 1'b0;
            hold_reg      <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_STAGES-2:0], signal_in};
            debnc_cnt_reg <= debnc_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
            level_reg     <= level_next;
            rise_reg      <= rise_next;
            fall_reg      <= fall_next;
            hold_reg      <= hold_next;
        end
    end

    assign signal_out = level_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;
    assign hold_pulse = hold_reg;
    assign event_next = rise_next | fall_next;

endmodule

// File: rtl/debounce_edge.sv
// Multi-channel debouncer with edge and long-press event pulses.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int   PORT_WIDTH   = 4,
    parameter int   DEBNC_CLOCKS = DEBNC_CLOCKS_DEF,
    parameter int   SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int   HOLD_CLOCKS  = HOLD_CLOCKS_DEF,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_WIDTH-1:0] signal_in,
    output logic [PORT_WIDTH-1:0] signal_out,
    output logic [PORT_WIDTH-1:0] rise_pulse,
    output logic [PORT_WIDTH-1:0] fall_pulse,
    output logic [PORT_WIDTH-1:0] hold_pulse,
    output logic                  any_event
);

    logic [PORT_WIDTH-1:0] event_next;
    logic                  any_event_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PORT_WIDTH; gi++) begin : g_chan
            debounce_edge_channel #(
                .DEBNC_CLOCKS (DEBNC_CLOCKS),
                .SYNC_STAGES  (SYNC_STAGES),
                .HOLD_CLOCKS  (HOLD_CLOCKS),
                .RESET_LEVEL  (RESET_LEVEL)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .signal_in  (signal_in[gi]),
                .signal_out (signal_out[gi]),
                .rise_pulse (rise_pulse[gi]),
                .fall_pulse (fall_pulse[gi]),
                .hold_pulse (hold_pulse[gi]),
                .event_next (event_next[gi])
            );
        end
    endgenerate

    // Registered from the channels' next-state terms so it lines up with the pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_event_reg <= 1'b0;
        end else begin
            any_event_reg <= |event_next;
        end
    end

    assign any_event = any_event_reg;

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: directed scenarios plus random
// stimulus, all compared cycle by cycle against a run-length reference model.
module tb_debounce_edge;

    localparam int PW = 4;
    localparam int DB = 4;
    localparam int SS = 2;
    localparam int HC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] signal_in;
    logic [PW-1:0] signal_out, rise_pulse, fall_pulse, hold_pulse;
    logic          any_event;

    int total = 0;
    int bad   = 0;

    // Reference model: delayed sample history, consecutive-mismatch run
    // length and consecutive-high run length per channel.
    logic [SS-1:0] m_hist [PW];
    int            m_run  [PW];
    int            m_high [PW];
    logic [PW-1:0] m_level, m_rise, m_fall, m_hold;
    logic          m_any;

    always #5 clk = ~clk;

    debounce_edge #(
        .PORT_WIDTH   (PW),
        .DEBNC_CLOCKS (DB),
        .SYNC_STAGES  (SS),
        .HOLD_CLOCKS  (HC),
        .RESET_LEVEL  (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .signal_out (signal_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .hold_pulse (hold_pulse),
        .any_event  (any_event)
    );

    // Advance one rising edge and update the reference model; outputs are
    // observed 1 time unit later.
    task automatic tick();
        logic seen;
        @(posedge clk);
        for (int i = 0; i < PW; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_hold[i] = 1'b0;
            if (rst) begin
                m_hist[i]  = '0;
                m_run[i]   = 0;
                m_high[i]  = 0;
                m_level[i] = 1'b0;
            end else begin
                seen      = m_hist[i][SS-1];
                m_hist[i] = {m_hist[i][SS-2:0], signal_in[i]};
                if (seen != m_level[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_run[i]   = 0;
                        m_level[i] = seen;
                        m_rise[i]  = seen;
                        m_fall[i]  = ~seen;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_level[i]) begin
                    if (m_high[i] < HC) begin
                        m_high[i] = m_high[i] + 1;
                        m_hold[i] = (m_high[i] == HC);
                    end
                end else begin
                    m_high[i] = 0;
                end
            end
        end
        m_any = |{m_rise, m_fall};
        #1;
    endtask

    task automatic settle(input int n);
        signal_in = '0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        bit found = 0;
        signal_in = 4'hF;
        rst = 1'b1;
        repeat (3) begin
            tick();
            total++;
            if ({signal_out, rise_pulse, fall_pulse, hold_pulse, any_event} !== 17'h0) begin
                bad++;
                $display("FAIL reset_hold got=%h exp=0", {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event});
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if ({signal_out, rise_pulse, fall_pulse, hold_pulse, any_event} !== {m_level, m_rise, m_fall, m_hold, m_any}) begin
                bad++;
                $display("FAIL reset_model k=%0d got=%h exp=%h", k, {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event}, {m_level, m_rise, m_fall, m_hold, m_any});
            end
            if (k == 1) begin
                total++;
                if (signal_out !== 4'h0 || rise_pulse !== 4'h0) begin
                    bad++;
                    $display("FAIL reset_first got out=%h rise=%h exp 0/0", signal_out, rise_pulse);
                end
            end
            if (!found && signal_out === 4'hF) begin
                found = 1;
                total++;
                if (k != 6 || rise_pulse !== 4'hF) begin
                    bad++;
                    $display("FAIL reset_latency got edge=%0d rise=%h exp edge=6 rise=f", k, rise_pulse);
                end
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reset_timeout got out=%h exp f", signal_out);
        end
        $display("reset: release with inputs high, rise seen=%0d", found);
        settle(16);
    endtask

    task automatic test_clean_step();
        bit found = 0;
        int rises = 0;
        signal_in = 4'h1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            total++;
            if ({signal_out, rise_pulse, fall_pulse, hold_pulse, any_event} !== {m_level, m_rise, m_fall, m_hold, m_any}) begin
                bad++;
                $display("FAIL step_model k=%0d got=%h exp=%h", k, {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event}, {m_level, m_rise, m_fall, m_hold, m_any});
            end
            rises += int'(rise_pulse[0]);
            if (!found && signal_out[0] === 1'b1) begin
                found = 1;
                total++;
                if (k != 6 || rise_pulse !== 4'h1 || any_event !== 1'b1 || signal_out[3:1] !== 3'b000) begin
                    bad++;
                    $display("FAIL step_rise got edge=%0d rise=%h any=%b out=%h exp edge=6 rise=1 any=1 out=1", k, rise_pulse, any_event, signal_out);
                end
            end
        end
        total++;
        if (!found || rises != 1) begin
            bad++;
            $display("FAIL step_count got found=%0d rises=%0d exp 1/1", found, rises);
        end
        $display("clean_step: ch0 rises=%0d", rises);
        settle(20);
    endtask

    task automatic test_glitch();
        int activity = 0;
        signal_in = 4'h2;
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) signal_in = 4'h0;
            tick();
            total++;
            if ({signal_out, rise_pulse, fall_pulse, hold_pulse, any_event} !== {m_level, m_rise, m_fall, m_hold, m_any}) begin
                bad++;
                $display("FAIL glitch_model k=%0d got=%h exp=%h", k, {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event}, {m_level, m_rise, m_fall, m_hold, m_any});
            end
            activity += int'(signal_out[1] | rise_pulse[1] | fall_pulse[1] | any_event);
        end
        total++;
        if (activity != 0) begin
            bad++;
            $display("FAIL glitch_quiet got activity=%0d exp 0", activity);
        end
        $display("glitch: 3-cycle pulse on ch1, activity=%0d", activity);
        settle(8);
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b10101;
        int rises = 0;
        int rise_k = -1;
        for (int k = 1; k <= 18; k++) begin
            signal_in = '0;
            signal_in[2] = (k <= 5) ? pat[k-1] : 1'b1;
            tick();
            total++;
            if ({signal_out, rise_pulse, fall_pulse, hold_pulse, any_event} !== {m_level, m_rise, m_fall, m_hold, m_any}) begin
                bad++;
                $display("FAIL bounce_model k=%0d got=%h exp=%h", k, {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event}, {m_level, m_rise, m_fall, m_hold, m_any});
            end
            if (rise_pulse[2] === 1'b1) begin
                rises++;
                rise_k = k;
            end
        end
        total++;
        if (rises != 1 || rise_k != 10) begin
            bad++;
            $display("FAIL bounce_rise got rises=%0d edge=%0d exp 1 at edge 10", rises, rise_k);
        end
        $display("bounce: ch2 rises=%0d at edge %0d", rises, rise_k);
        settle(24);
    endtask

    task automatic test_hold();
        for (int press = 0; press < 3; press++) begin
            int hi_len = (press < 2) ? 26 : 5;
            int rise_k = -1, hold_k = -1, fall_k = -1, holds = 0, rises = 0, falls = 0;
            for (int k = 1; k <= 40; k++) begin
                signal_in = (k <= hi_len) ? 4'h8 : 4'h0;
                tick();
                total++;
                if ({signal_out, rise_pulse, fall_pulse, hold_pulse, any_event} !== {m_level, m_rise, m_fall, m_hold, m_any}) begin
                    bad++;
                    $display("FAIL hold_model p=%0d k=%0d got=%h exp=%h", press, k, {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event}, {m_level, m_rise, m_fall, m_hold, m_any});
                end
                if (rise_pulse[3] === 1'b1) begin rises++; rise_k = k; end
                if (fall_pulse[3] === 1'b1) begin falls++; fall_k = k; end
                if (hold_pulse[3] === 1'b1) begin holds++; hold_k = k; end
            end
            total++;
            if (press < 2) begin
                if (rises != 1 || rise_k != 6 || holds != 1 || hold_k - rise_k != HC - 1 || falls != 1 || fall_k != 32) begin
                    bad++;
                    $display("FAIL hold_long p=%0d got rise@%0d hold@%0d(x%0d) fall@%0d exp rise@6 hold@13(x1) fall@32", press, rise_k, hold_k, holds, fall_k);
                end
            end else begin
                if (rises != 1 || holds != 0 || falls != 1 || fall_k != 11) begin
                    bad++;
                    $display("FAIL hold_short got rises=%0d holds=%0d fall@%0d exp 1/0/11", rises, holds, fall_k);
                end
            end
            $display("hold: press %0d len=%0d rise@%0d hold@%0d fall@%0d", press, hi_len, rise_k, hold_k, fall_k);
        end
        settle(8);
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int r0 = -1, r3 = -1, h3 = -1, pulses = 0;
        signal_in = 4'h8;
        for (int k = 1; k <= 12 && !found; k++) begin
            tick();
            if (rise_pulse[3] === 1'b1) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mid_timeout got rise3=0 exp 1");
        end
        signal_in = 4'h9;
        repeat (4) begin
            tick();
            pulses += int'(|{rise_pulse[0], hold_pulse[3], fall_pulse});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (pulses != 0 || {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event} !== 17'h0) begin
            bad++;
            $display("FAIL mid_reset got pulses=%0d outs=%h exp 0/0", pulses, {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event});
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if ({signal_out, rise_pulse, fall_pulse, hold_pulse, any_event} !== {m_level, m_rise, m_fall, m_hold, m_any}) begin
                bad++;
                $display("FAIL mid_model k=%0d got=%h exp=%h", k, {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event}, {m_level, m_rise, m_fall, m_hold, m_any});
            end
            if (rise_pulse[0] === 1'b1) r0 = k;
            if (rise_pulse[3] === 1'b1) r3 = k;
            if (hold_pulse[3] === 1'b1) h3 = k;
        end
        total++;
        if (r0 != 6 || r3 != 6 || h3 != 6 + HC - 1) begin
            bad++;
            $display("FAIL mid_restart got r0@%0d r3@%0d h3@%0d exp 6/6/13", r0, r3, h3);
        end
        $display("reset_mid: restart r0@%0d r3@%0d h3@%0d", r0, r3, h3);
        settle(16);
    endtask

    task automatic test_random();
        int bnc [PW];
        int errs = 0;
        for (int i = 0; i < PW; i++) bnc[i] = 0;
        for (int n = 0; n < 900; n++) begin
            for (int i = 0; i < PW; i++) begin
                if (bnc[i] > 0) begin
                    signal_in[i] = 1'($urandom_range(0, 1));
                    bnc[i]--;
                end else if ($urandom_range(0, 15) == 0) begin
                    signal_in[i] = ~signal_in[i];
                    if ($urandom_range(0, 2) == 0) bnc[i] = int'($urandom_range(1, 6));
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
            total++;
            if ({signal_out, rise_pulse, fall_pulse, hold_pulse, any_event} !== {m_level, m_rise, m_fall, m_hold, m_any}) begin
                bad++;
                errs++;
                $display("FAIL random_model n=%0d in=%h got=%h exp=%h", n, signal_in, {signal_out, rise_pulse, fall_pulse, hold_pulse, any_event}, {m_level, m_rise, m_fall, m_hold, m_any});
            end
        end
        rst = 1'b0;
        $display("random: 900 cycles, errors=%0d", errs);
    endtask

    initial begin
        rst = 1'b1;
        signal_in = '0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish exp finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Multi-channel debouncer for buttons and switches. Successor to the plain toggle-on-count debouncer.
- Adds per channel:
  - an input synchroniser;
  - a synchronous reset with a configurable idle level;
  - registered rise and fall event pulses;
  - a one-shot long-press (hold) detector.
- Sits between raw board pins and control FSMs. Consumers use the pulses directly instead of doing their own edge detection.

Parameters:
- PORT_WIDTH, 4: number of independent channels.
- DEBNC_CLOCKS, 16: consecutive mismatch cycles required before the debounced level toggles (>=1).
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (>=2).
- HOLD_CLOCKS, 1024: cycles signal_out must stay high before hold_pulse fires (>=1).
- RESET_LEVEL, 1'b0: value loaded into the synchroniser and signal_out on reset.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- signal_in, input, PORT_WIDTH: raw asynchronous inputs.
- signal_out, output, PORT_WIDTH: debounced levels.
- rise_pulse, output, PORT_WIDTH: one-cycle pulse on a debounced 0->1 change.
- fall_pulse, output, PORT_WIDTH: one-cycle pulse on a debounced 1->0 change.
- hold_pulse, output, PORT_WIDTH: one-cycle pulse once per press, when the high level reaches HOLD_CLOCKS.
- any_event, output, 1: OR of all rise_pulse and fall_pulse bits (registered).

Behaviour:
- Reset (rst=1 at a clk edge):
  - all synchroniser stages and signal_out = RESET_LEVEL;
  - all counters = 0;
  - rise_pulse, fall_pulse, hold_pulse, any_event = 0.
  - Reset mid-count or mid-hold discards all progress. No pulse is generated by reset itself, even if the level changes.
- Synchroniser: signal_in[i] passes through SYNC_STAGES flops; sync[i] is the last stage. No logic between stages.
- Debounce counter:
  - width = $clog2(DEBNC_CLOCKS+1).
  - If sync[i] != signal_out[i]: counter increments, unless it equals DEBNC_CLOCKS-1. In that case signal_out[i] toggles at this edge and the counter clears.
  - If sync[i] == signal_out[i]: counter clears. Any single matching cycle restarts the count.
  - DEBNC_CLOCKS=1: toggle on the first mismatch cycle.
- Latency: a clean level change on signal_in, first sampled at edge E, appears on signal_out at edge E+SYNC_STAGES+DEBNC_CLOCKS-1. That is SYNC_STAGES+DEBNC_CLOCKS edges inclusive.
- Pulses:
  - rise_pulse[i] / fall_pulse[i] are registered alongside the toggle. They are high for exactly the first cycle signal_out[i] shows the new level.
  - any_event is registered from the same next-state terms and is coincident with them.
- Hold counter:
  - width = $clog2(HOLD_CLOCKS+1).
  - Clears while signal_out[i]=0.
  - Counts 1..HOLD_CLOCKS while signal_out[i]=1 (the first high cycle counts as 1), then saturates.
  - hold_pulse[i] is high for one cycle, in the cycle when the count reaches HOLD_CLOCKS.
  - A release before HOLD_CLOCKS gives no hold_pulse; fall_pulse still fires.
  - With HOLD_CLOCKS=1, hold_pulse coincides with rise_pulse.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses with no arbitration.
- No combinational path from any input to any output.

Decomposition:
- Package debounce_pkg holds:
  - the counter-width helper functions (debounce count width, hold count width);
  - the default constants DEBNC_CLOCKS_DEF, SYNC_STAGES_DEF, HOLD_CLOCKS_DEF.
- Sub-module debounce_edge_channel holds one channel: synchroniser, debounce counter, level register, pulse registers, hold counter.
- The top instantiates PORT_WIDTH copies in a generate loop and ORs the pulses into any_event.

Test Plan:
All scenarios use PORT_WIDTH=4, DEBNC_CLOCKS=4, SYNC_STAGES=2, HOLD_CLOCKS=8, RESET_LEVEL=0.
- Reset: signal_in=4'hF, rst held 3 cycles -> all outputs 0 during reset and in the first cycle after. Then signal_out=4'hF exactly 6 edges after reset release, with rise_pulse=4'hF for one cycle.
- Clean step: ch0 goes 0->1, first sampled at edge E -> signal_out[0]=1 after edge E+5; rise_pulse[0] and any_event high only in that cycle; other channels stay 0.
- Glitch: ch1 high for exactly 3 cycles, then 0 -> signal_out[1] stays 0; no pulses.
- Bounce: ch2 pattern 1,0,1,0,1 (one cycle each), then held 1 -> signal_out[2] rises 6 edges after the final 0->1 sample; exactly one rise_pulse.
- Hold and release: ch3 held high 20 cycles after the debounced rise -> one hold_pulse[3], 8 cycles after rise_pulse[3], none afterwards. Release -> fall_pulse[3] 6 edges later. A re-press repeats the same sequence. A 5-cycle press gives no hold_pulse.
- Reset mid-operation: rst pulsed while ch0 counter=2 and ch3 hold count=5 -> no pulses. After release, the counts restart from 0: full 6-edge latency and a full 8-cycle hold.
